// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: instruction memory port plus the IF/ID register outputs.
// The master side is the fetch stage. The slave side is the memory/decode.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_pc;
  logic [31:0] id_pcp4;
  logic [31:0] id_ins;
  logic        id_valid;

  modport master (
    output imem_addr,
    input  imem_data,
    output id_pc,
    output id_pcp4,
    output id_ins,
    output id_valid
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    input  id_pc,
    input  id_pcp4,
    input  id_ins,
    input  id_valid
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// delivered-instruction counter, with redirect/flush/stall control.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  if_fetch_stage_if.master fif,
  output logic [31:0]      fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [31:0] ins;
    logic        valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{
    pc:    32'h0,
    pcp4:  32'h0,
    ins:   NOP_INS,
    valid: 1'b0
  };

  logic [31:0] pc_q, pc_d;
  logic [31:0] cnt_q, cnt_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] pc_plus4;
  logic        do_redir;
  logic        do_flush;
  logic        do_hold;

  assign pc_plus4 = pc_q + 32'd4;

  // Mutually exclusive action selects, redirect first.
  assign do_redir = redirect_valid;
  assign do_flush = !redirect_valid && flush;
  assign do_hold  = !redirect_valid && !flush && stall;

  always_comb begin
    pc_d   = pc_q;
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      do_redir: begin
        pc_d   = redirect_pc & ~32'h3;
        ifid_d = BUBBLE;
      end
      do_flush: begin
        ifid_d = BUBBLE;
        if (!stall) pc_d = pc_plus4;
      end
      do_hold: begin
        pc_d = pc_q;
      end
      default: begin
        pc_d         = pc_plus4;
        ifid_d.pc    = pc_q;
        ifid_d.pcp4  = pc_plus4;
        ifid_d.ins   = fif.imem_data;
        ifid_d.valid = 1'b1;
        cnt_d        = cnt_q + 32'd1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= BUBBLE;
      cnt_q  <= 32'h0;
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
      cnt_q  <= cnt_d;
    end
  end

  assign fif.imem_addr = pc_q;
  assign fif.id_pc     = ifid_q.pc;
  assign fif.id_pcp4   = ifid_q.pcp4;
  assign fif.id_ins    = ifid_q.ins;
  assign fif.id_valid  = ifid_q.valid;
  assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios then random control traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] fetch_count;
  logic [31:0] salt = 32'hA5A5_0000;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] m_pc, m_id_pc, m_id_pcp4, m_id_ins, m_cnt;
  logic        m_valid;

  if_fetch_stage_if bus ();

  assign bus.imem_data = bus.imem_addr ^ salt;

  if_fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INS  (NOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fif            (bus.master),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".imem_addr"}, bus.imem_addr, m_pc);
    chk({tag, ".id_pc"}, bus.id_pc, m_id_pc);
    chk({tag, ".id_pcp4"}, bus.id_pcp4, m_id_pcp4);
    chk({tag, ".id_ins"}, bus.id_ins, m_id_ins);
    chk({tag, ".id_valid"}, {31'h0, bus.id_valid}, {31'h0, m_valid});
    chk({tag, ".fetch_count"}, fetch_count, m_cnt);
  endtask

  task automatic bubble();
    m_id_pc   = 32'h0;
    m_id_pcp4 = 32'h0;
    m_id_ins  = NOP;
    m_valid   = 1'b0;
  endtask

  // What one clock edge does, given this cycle's controls.
  task automatic model(input logic r, input logic s, input logic f,
                       input logic rv, input logic [31:0] rpc);
    logic [31:0] word;
    word = m_pc ^ salt;
    if (r) begin
      m_pc  = RST_PC;
      m_cnt = 0;
      bubble();
    end else if (rv) begin
      m_pc = (rpc / 4) * 4;
      bubble();
    end else if (f) begin
      bubble();
      if (!s) m_pc = m_pc + 4;
    end else if (!s) begin
      m_id_pc   = m_pc;
      m_id_pcp4 = m_pc + 4;
      m_id_ins  = word;
      m_valid   = 1'b1;
      m_pc      = m_pc + 4;
      m_cnt     = m_cnt + 1;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic s,
                      input logic f, input logic rv,
                      input logic [31:0] rpc);
    reset          = r;
    stall          = s;
    flush          = f;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model(r, s, f, rv, rpc);
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  initial begin
    m_pc = 'x; m_id_pc = 'x; m_id_pcp4 = 'x;
    m_id_ins = 'x; m_cnt = 'x; m_valid = 1'bx;

    step("reset", 1, 0, 0, 0, 0);
    chk("reset.addr0", bus.imem_addr, 32'h0);

    step("adv1", 0, 0, 0, 0, 0);
    chk("adv1.ins", bus.id_ins, 32'hA5A5_0000);
    step("adv2", 0, 0, 0, 0, 0);
    chk("adv2.ins", bus.id_ins, 32'hA5A5_0004);

    step("stall1", 0, 1, 0, 0, 0);
    step("stall2", 0, 1, 0, 0, 32'h1234);
    chk("stall.addr", bus.imem_addr, 32'h8);
    chk("stall.id_pc", bus.id_pc, 32'h4);
    chk("stall.cnt", fetch_count, 32'd2);

    step("release", 0, 0, 0, 0, 0);
    chk("release.id_pc", bus.id_pc, 32'h8);
    chk("release.ins", bus.id_ins, 32'hA5A5_0008);
    chk("release.cnt", fetch_count, 32'd3);

    step("flush_stall", 0, 1, 1, 0, 0);
    chk("flush_stall.addr", bus.imem_addr, 32'hC);
    chk("flush_stall.ins", bus.id_ins, NOP);
    step("flush", 0, 0, 1, 0, 0);
    chk("flush.addr", bus.imem_addr, 32'h10);

    step("redir", 0, 1, 0, 1, 32'h0040_0023);
    chk("redir.addr", bus.imem_addr, 32'h0040_0020);
    chk("redir.valid", {31'h0, bus.id_valid}, 32'h0);
    step("redir_adv", 0, 0, 0, 0, 0);
    chk("redir_adv.id_pc", bus.id_pc, 32'h0040_0020);
    chk("redir_adv.pcp4", bus.id_pcp4, 32'h0040_0024);

    step("redir_flush", 0, 1, 1, 1, 32'h0000_0101);
    step("wrap_redir", 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("wrap_adv", 0, 0, 0, 0, 0);
    chk("wrap.id_pc", bus.id_pc, 32'hFFFF_FFFC);
    chk("wrap.pcp4", bus.id_pcp4, 32'h0);
    chk("wrap.addr", bus.imem_addr, 32'h0);

    step("pre_rst", 0, 0, 0, 0, 0);
    step("rst_redir", 1, 1, 1, 1, 32'h0000_0400);
    chk("rst_redir.addr", bus.imem_addr, RST_PC);
    chk("rst_redir.cnt", fetch_count, 32'h0);
    step("post_rst", 0, 0, 0, 0, 0);
    chk("post_rst.ins", bus.id_ins, RST_PC ^ salt);

    for (int i = 0; i < 400; i++) begin
      logic r, s, f, rv;
      if (i % 50 == 0) salt = $urandom;
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 7) == 0);
      rv = ($urandom_range(0, 9) == 0);
      step("rand", r, s, f, rv, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
